// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg
//   Shared definitions for the user-pad configuration serializer: default
//   word width and reset value, bit positions inside a pad configuration
//   word, the transfer FSM state encoding and the chain-length helper.
package gpio_cfg_pkg;

  localparam int CFG_BITS_DEF = 13;

  // Field offsets inside one pad configuration word (LSB first).
  localparam int CFG_MGMT_EN  = 0;
  localparam int CFG_OEB      = 1;
  localparam int CFG_HLDH     = 2;
  localparam int CFG_INP_DIS  = 3;
  localparam int CFG_IB_MODE  = 4;
  localparam int CFG_ANA_EN   = 5;
  localparam int CFG_ANA_SEL  = 6;
  localparam int CFG_ANA_POL  = 7;
  localparam int CFG_SLOW_SEL = 8;
  localparam int CFG_VTRIP    = 9;
  localparam int CFG_DM_LSB   = 10;
  localparam int CFG_DM_W     = 3;

  // Management-owned pad, output driver disabled, dm = 3'b001.
  localparam logic [12:0] DEFAULT_CFG_DEF = 13'h0403;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LOAD,
    ST_DONE
  } state_t;

  // Bits per chain: both chains are padded to the longer one.
  function automatic int chain_len(input int num_pads, input int split, input int cfg_bits);
    return cfg_bits * ((split > num_pads - split) ? split : (num_pads - split));
  endfunction

endpackage

// File: rtl/gpio_cfg_bitsel.sv
// gpio_cfg_bitsel
//   Combinational map from a chain's down-counting bit position to the pad
//   word and bit that must be driven at that position.
//   Ports:
//     chain2    : 0 = chain 1 (pads SPLIT-1..0), 1 = chain 2 (pads SPLIT..NUM_PADS-1)
//     bit_cnt   : bits still to follow this one (L-1 for the first bit, 0 for the last)
//     word_idx  : pad index to read (0 when pad_zero)
//     bit_idx   : bit within that pad word
//     pad_zero  : position is a leading fill bit of the shorter chain
module gpio_cfg_bitsel
  import gpio_cfg_pkg::*;
#(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int SPLIT    = 19,
  parameter int AW       = 6,
  parameter int BW       = 4,
  parameter int BCW      = 9
) (
  input  logic           chain2,
  input  logic [BCW-1:0] bit_cnt,
  output logic [AW-1:0]  word_idx,
  output logic [BW-1:0]  bit_idx,
  output logic           pad_zero
);

  localparam int unsigned CB_U    = CFG_BITS;
  localparam int unsigned SPLIT_U = SPLIT;
  localparam int unsigned PADS_U  = NUM_PADS;

  int unsigned pos_u;
  int unsigned word_from_end;

  // The last bit shifted out of each chain is the LSB of the nearest pad
  // (pad 0 on chain 1, pad NUM_PADS-1 on chain 2), so counting from the end
  // of the stream gives the word/bit directly; positions beyond the chain's
  // own pads are the leading fill zeros.
  always_comb begin
    pos_u         = 32'(bit_cnt);
    word_from_end = pos_u / CB_U;
    bit_idx       = BW'(pos_u % CB_U);
    word_idx      = '0;
    pad_zero      = 1'b1;
    if (!chain2) begin
      if (word_from_end < SPLIT_U) begin
        pad_zero = 1'b0;
        word_idx = AW'(word_from_end);
      end
    end else begin
      if (word_from_end < (PADS_U - SPLIT_U)) begin
        pad_zero = 1'b0;
        word_idx = AW'(PADS_U - 32'd1 - word_from_end);
      end
    end
  end

endmodule

// File: rtl/gpio_cfg_serializer.sv
// gpio_cfg_serializer
//   Holds one configuration word per user pad and shifts all words out over
//   two parallel daisy chains, then strobes a load into every pad.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | outputs 0, writes accepted, waits for xfer_start
//   SHIFT_LO  | serial_clock low, new data bit presented, CLK_DIV cycles
//   SHIFT_HI  | serial_clock high, data held, CLK_DIV cycles
//   LOAD      | serial_load high, clock/data low, 2*CLK_DIV cycles
//   DONE      | one-cycle xfer_done pulse, busy released
//
//   Ports:
//     clock, reset           : core clock, async active-high reset
//     cfg_we/addr/wdata      : word write (IDLE only, addr < NUM_PADS)
//     cfg_rdata              : registered read of word cfg_addr (0 if out of range)
//     cfg_err                : one-cycle pulse for a rejected write
//     xfer_start             : begin a transfer (sampled in IDLE)
//     xfer_busy, xfer_done   : transfer status
//     serial_clock/load      : shared shift clock and load strobe
//     serial_data_1/2        : chain 1 / chain 2 data
module gpio_cfg_serializer
  import gpio_cfg_pkg::*;
#(
  parameter int                  NUM_PADS    = 38,
  parameter int                  CFG_BITS    = CFG_BITS_DEF,
  parameter int                  SPLIT       = 19,
  parameter int                  CLK_DIV     = 2,
  parameter logic [CFG_BITS-1:0] DEFAULT_CFG = CFG_BITS'(DEFAULT_CFG_DEF)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_PADS)-1:0]   cfg_addr,
  input  logic [CFG_BITS-1:0]           cfg_wdata,
  output logic [CFG_BITS-1:0]           cfg_rdata,
  output logic                          cfg_err,
  input  logic                          xfer_start,
  output logic                          xfer_busy,
  output logic                          xfer_done,
  output logic                          serial_clock,
  output logic                          serial_load,
  output logic                          serial_data_1,
  output logic                          serial_data_2
);

  localparam int AW  = $clog2(NUM_PADS);
  localparam int L   = chain_len(NUM_PADS, SPLIT, CFG_BITS);
  localparam int BCW = $clog2(L + 1);
  localparam int BW  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int DW  = $clog2(2 * CLK_DIV);

  localparam logic [DW-1:0]  HALF_LOAD = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  LOAD_LOAD = DW'(2 * CLK_DIV - 1);
  localparam logic [BCW-1:0] BIT_FIRST = BCW'(L - 1);

  logic [CFG_BITS-1:0] cfg_mem [NUM_PADS];
  state_t              state;
  logic [DW-1:0]       div_cnt;
  logic [BCW-1:0]      bit_cnt;
  logic [BCW-1:0]      sel_cnt;
  logic                addr_ok;

  logic [AW-1:0] word_1, word_2;
  logic [BW-1:0] bit_1, bit_2;
  logic          pad_zero_1, pad_zero_2;
  logic          next_bit_1, next_bit_2;

  assign addr_ok = ({{(32-AW){1'b0}}, cfg_addr} < 32'(NUM_PADS));

  // Data is registered on entry to SHIFT_LO, so the selectors look at the
  // bit about to be presented: the first bit from IDLE, the next one from
  // SHIFT_HI. The underflow when bit_cnt is 0 falls into the fill region
  // and is never used.
  assign sel_cnt = (state == ST_IDLE) ? BIT_FIRST : (bit_cnt - 1'b1);

  gpio_cfg_bitsel #(
    .NUM_PADS (NUM_PADS),
    .CFG_BITS (CFG_BITS),
    .SPLIT    (SPLIT),
    .AW       (AW),
    .BW       (BW),
    .BCW      (BCW)
  ) u_bitsel_1 (
    .chain2   (1'b0),
    .bit_cnt  (sel_cnt),
    .word_idx (word_1),
    .bit_idx  (bit_1),
    .pad_zero (pad_zero_1)
  );

  gpio_cfg_bitsel #(
    .NUM_PADS (NUM_PADS),
    .CFG_BITS (CFG_BITS),
    .SPLIT    (SPLIT),
    .AW       (AW),
    .BW       (BW),
    .BCW      (BCW)
  ) u_bitsel_2 (
    .chain2   (1'b1),
    .bit_cnt  (sel_cnt),
    .word_idx (word_2),
    .bit_idx  (bit_2),
    .pad_zero (pad_zero_2)
  );

  assign next_bit_1 = pad_zero_1 ? 1'b0 : cfg_mem[word_1][bit_1];
  assign next_bit_2 = pad_zero_2 ? 1'b0 : cfg_mem[word_2][bit_2];

  // Register file: writes only while idle, reads always allowed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PADS; i++) cfg_mem[i] <= DEFAULT_CFG;
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_we) begin
        if (state == ST_IDLE && addr_ok) cfg_mem[cfg_addr] <= cfg_wdata;
        else                             cfg_err <= 1'b1;
      end
      cfg_rdata <= addr_ok ? cfg_mem[cfg_addr] : '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      xfer_busy     <= 1'b0;
      xfer_done     <= 1'b0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer_start) begin
            state         <= ST_SHIFT_LO;
            xfer_busy     <= 1'b1;
            div_cnt       <= HALF_LOAD;
            bit_cnt       <= BIT_FIRST;
            serial_data_1 <= next_bit_1;
            serial_data_2 <= next_bit_2;
          end
        end
        ST_SHIFT_LO: begin
          if (div_cnt == '0) begin
            state        <= ST_SHIFT_HI;
            serial_clock <= 1'b1;
            div_cnt      <= HALF_LOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (div_cnt == '0) begin
            serial_clock <= 1'b0;
            if (bit_cnt == '0) begin
              state         <= ST_LOAD;
              serial_load   <= 1'b1;
              serial_data_1 <= 1'b0;
              serial_data_2 <= 1'b0;
              div_cnt       <= LOAD_LOAD;
            end else begin
              state         <= ST_SHIFT_LO;
              bit_cnt       <= bit_cnt - 1'b1;
              serial_data_1 <= next_bit_1;
              serial_data_2 <= next_bit_2;
              div_cnt       <= HALF_LOAD;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_LOAD: begin
          if (div_cnt == '0) begin
            state       <= ST_DONE;
            serial_load <= 1'b0;
            xfer_done   <= 1'b1;
            xfer_busy   <= 1'b0;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          xfer_done <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          xfer_busy     <= 1'b0;
          xfer_done     <= 1'b0;
          serial_clock  <= 1'b0;
          serial_load   <= 1'b0;
          serial_data_1 <= 1'b0;
          serial_data_2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
module tb_gpio_cfg_serializer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Shared inputs of the two 4-pad instances (A: CLK_DIV=1, C: CLK_DIV=3).
  logic       we = 1'b0;
  logic [1:0] addr = '0;
  logic [2:0] wdata = '0;
  logic       start_a = 1'b0, start_c = 1'b0;

  logic [2:0] a_rdata, c_rdata;
  logic a_err, a_busy, a_done, a_sclk, a_load, a_d1, a_d2;
  logic c_err, c_busy, c_done, c_sclk, c_load, c_d1, c_d2;

  // Default-parameter instance B (38 pads).
  logic        b_we = 1'b0;
  logic [5:0]  b_addr = '0;
  logic [12:0] b_wdata = '0;
  logic        b_start = 1'b0;
  logic [12:0] b_rdata;
  logic b_err, b_busy, b_done, b_sclk, b_load, b_d1, b_d2;

  gpio_cfg_serializer #(.NUM_PADS(4), .CFG_BITS(3), .SPLIT(1), .CLK_DIV(1), .DEFAULT_CFG(3'b110)) u_a (
    .clock(clock), .reset(reset), .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata),
    .cfg_rdata(a_rdata), .cfg_err(a_err), .xfer_start(start_a), .xfer_busy(a_busy),
    .xfer_done(a_done), .serial_clock(a_sclk), .serial_load(a_load),
    .serial_data_1(a_d1), .serial_data_2(a_d2));

  gpio_cfg_serializer #(.NUM_PADS(4), .CFG_BITS(3), .SPLIT(1), .CLK_DIV(3), .DEFAULT_CFG(3'b110)) u_c (
    .clock(clock), .reset(reset), .cfg_we(we), .cfg_addr(addr), .cfg_wdata(wdata),
    .cfg_rdata(c_rdata), .cfg_err(c_err), .xfer_start(start_c), .xfer_busy(c_busy),
    .xfer_done(c_done), .serial_clock(c_sclk), .serial_load(c_load),
    .serial_data_1(c_d1), .serial_data_2(c_d2));

  gpio_cfg_serializer u_b (
    .clock(clock), .reset(reset), .cfg_we(b_we), .cfg_addr(b_addr), .cfg_wdata(b_wdata),
    .cfg_rdata(b_rdata), .cfg_err(b_err), .xfer_start(b_start), .xfer_busy(b_busy),
    .xfer_done(b_done), .serial_clock(b_sclk), .serial_load(b_load),
    .serial_data_1(b_d1), .serial_data_2(b_d2));

  logic [6:0] obs_a, obs_c, obs_b;
  assign obs_a = {a_busy, a_done, a_load, a_sclk, a_d1, a_d2, a_err};
  assign obs_c = {c_busy, c_done, c_load, c_sclk, c_d1, c_d2, c_err};
  assign obs_b = {b_busy, b_done, b_load, b_sclk, b_d1, b_d2, b_err};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ad, input logic [2:0] d);
    @(negedge clock);
    we = 1'b1; addr = ad; wdata = d;
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic rd_a(input logic [1:0] ad, input logic [2:0] ex, input string tag);
    @(negedge clock);
    addr = ad;
    @(negedge clock);
    chk(tag, int'(ad), 32'(a_rdata), 32'(ex));
  endtask

  task automatic rd_b(input int ad, input logic [12:0] ex);
    @(negedge clock);
    b_addr = ad[5:0];
    @(negedge clock);
    chk("rd_big", ad, 32'(b_rdata), 32'(ex));
  endtask

  // Checks every cycle of one transfer of the 4-pad / 3-bit instances (L=9),
  // cycle 1 being the first after the accepting edge. Expected vector:
  // {busy, done, load, sclk, d1, d2, err}.
  task automatic run_xfer(input bit use_c, input int div, input logic [8:0] cv1,
                          input logic [8:0] cv2, input bit inject, input bit keep);
    int shift_end, n_end, j, ph;
    logic [6:0] e, o;
    shift_end = 2 * div * 9;
    n_end     = 2 * div * 10 + 2;
    if (use_c) start_c = 1'b1; else start_a = 1'b1;
    for (int n = 1; n <= n_end; n++) begin
      @(negedge clock);
      if (n == 1 && !keep) begin start_a = 1'b0; start_c = 1'b0; end
      e = '0;
      if (n <= shift_end) begin
        j  = (n - 1) / (2 * div);
        ph = (n - 1) % (2 * div);
        e[6] = 1'b1;
        e[3] = (ph >= div);
        e[2] = cv1[8 - j];
        e[1] = cv2[8 - j];
      end else if (n <= shift_end + 2 * div) begin
        e[6] = 1'b1;
        e[4] = 1'b1;
      end else if (n == shift_end + 2 * div + 1) begin
        e[5] = 1'b1;
      end
      e[0] = inject && (n == 6);
      o = use_c ? obs_c : obs_a;
      chk(use_c ? "stream_c" : "stream_a", n, 32'(o), 32'(e));
      if (inject && n == 5) begin we = 1'b1; addr = 2'd2; wdata = 3'b000; start_a = 1'b1; end
      if (inject && n == 6) begin we = 1'b0; start_a = 1'b0; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    // Reset: everything low while held.
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_out_a", 0, 32'({obs_a, a_rdata}), 32'd0);
    chk("rst_out_c", 0, 32'({obs_c, c_rdata}), 32'd0);
    chk("rst_out_b", 0, 32'({obs_b, b_rdata}), 32'd0);
    reset = 1'b0;

    // Default words on the 38-pad instance; out-of-range read gives 0.
    for (int i = 0; i < 38; i++) rd_b(i, 13'h0403);
    rd_b(38, 13'h0000);

    // Out-of-range write rejected with a one-cycle error pulse.
    @(negedge clock);
    b_we = 1'b1; b_addr = 6'd38; b_wdata = 13'h1fff;
    @(negedge clock);
    b_we = 1'b0;
    chk("err_range", 1, 32'(b_err), 32'd1);
    @(negedge clock);
    chk("err_range", 2, 32'(b_err), 32'd0);
    rd_b(37, 13'h0403);
    @(negedge clock);
    b_we = 1'b1; b_addr = 6'd5; b_wdata = 13'h0abc;
    @(negedge clock);
    b_we = 1'b0;
    chk("err_inrange", 1, 32'(b_err), 32'd0);
    rd_b(5, 13'h0abc);

    // Program the 4-pad words and read them back.
    wr(2'd0, 3'b101);
    wr(2'd1, 3'b001);
    wr(2'd2, 3'b010);
    wr(2'd3, 3'b111);
    rd_a(2'd0, 3'b101, "rd_a");
    rd_a(2'd1, 3'b001, "rd_a");
    rd_a(2'd2, 3'b010, "rd_a");
    rd_a(2'd3, 3'b111, "rd_a");

    // Chain 1: six fill zeros then pad 0; chain 2: pads 1,2,3 MSB first.
    run_xfer(1'b0, 1, 9'b000000101, 9'b001010111, 1'b0, 1'b0);
    run_xfer(1'b1, 3, 9'b000000101, 9'b001010111, 1'b0, 1'b0);

    // Write and restart while busy: dropped, error pulse, same timing.
    run_xfer(1'b0, 1, 9'b000000101, 9'b001010111, 1'b1, 1'b0);
    rd_a(2'd2, 3'b010, "busy_wr_a");

    // Reset at bit 5 of a transfer.
    @(negedge clock);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (10) @(negedge clock);
    chk("abort_busy", 11, 32'(a_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_out_a", 0, 32'(obs_a), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (a_load || a_done) seen = 1'b1;
    end
    chk("abort_no_load_done", 0, 32'(seen), 32'd0);
    rd_a(2'd0, 3'b110, "abort_rd");
    rd_a(2'd1, 3'b110, "abort_rd");
    rd_a(2'd2, 3'b110, "abort_rd");
    rd_a(2'd3, 3'b110, "abort_rd");

    // Fresh transfer of the default words.
    run_xfer(1'b0, 1, 9'b000000110, 9'b110110110, 1'b0, 1'b0);

    // Back-to-back with xfer_start held high.
    wr(2'd0, 3'b101);
    wr(2'd1, 3'b001);
    wr(2'd2, 3'b010);
    wr(2'd3, 3'b111);
    run_xfer(1'b0, 1, 9'b000000101, 9'b001010111, 1'b0, 1'b1);
    run_xfer(1'b0, 1, 9'b000000101, 9'b001010111, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
